// File: rtl/vp_pingpong_encoder.sv
// Sparse-stream encoder: scans a lookahead window for valid entries and packs them
// into two ping-pong banks of LANES slots, handing full banks to a consumer in order.
module vp_pingpong_encoder #(
    parameter int LANES  = 3,
    parameter int SCAN   = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 21,
    parameter int IDX_W  = 11
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [IDX_W-1:0]             i_len,
    output logic                         o_busy,
    output logic [IDX_W-1:0]             o_idx,
    input  logic [SCAN-1:0]              i_win_valid,
    input  logic [SCAN*DATA_W-1:0]       i_win_w,
    input  logic [SCAN*DATA_W-1:0]       i_win_ia,
    input  logic [SCAN*ADDR_W-1:0]       i_win_addr,
    output logic                         o_out_valid,
    input  logic                         i_out_ack,
    output logic                         o_out_bank,
    output logic [$clog2(LANES+1)-1:0]   o_out_count,
    output logic [LANES*DATA_W-1:0]      o_out_w,
    output logic [LANES*DATA_W-1:0]      o_out_ia,
    output logic [LANES*ADDR_W-1:0]      o_out_addr,
    output logic                         o_done
);

    localparam int CNT_W = $clog2(LANES + 1);
    localparam int SEL_W = (SCAN > 1) ? $clog2(SCAN) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FLUSH, ST_DRAIN} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   len_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   pos_reg;
    logic               fill_reg;
    logic               head_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [1:0]         full_reg;
    logic [CNT_W-1:0]   count_reg [2];

    logic [DATA_W-1:0]  w_reg    [2][LANES];
    logic [DATA_W-1:0]  ia_reg   [2][LANES];
    logic [ADDR_W-1:0]  addr_reg [2][LANES];

    logic [DATA_W-1:0]  win_w    [SCAN];
    logic [DATA_W-1:0]  win_ia   [SCAN];
    logic [ADDR_W-1:0]  win_addr [SCAN];
    logic [SCAN-1:0]    eff_valid;

    logic               hit;
    logic [SEL_W-1:0]   sel;
    logic [IDX_W:0]     adv;
    logic [IDX_W:0]     idx_sum;
    logic [IDX_W-1:0]   idx_next;

    // Entries at or beyond the latched length never count as valid.
    generate
        for (genvar gi = 0; gi < SCAN; gi++) begin : g_win
            logic [IDX_W:0] ent_idx;
            assign ent_idx       = {1'b0, idx_reg} + (IDX_W+1)'(gi);
            assign win_w[gi]     = i_win_w[gi*DATA_W +: DATA_W];
            assign win_ia[gi]    = i_win_ia[gi*DATA_W +: DATA_W];
            assign win_addr[gi]  = i_win_addr[gi*ADDR_W +: ADDR_W];
            assign eff_valid[gi] = i_win_valid[gi] && (ent_idx < {1'b0, len_reg});
        end
    endgenerate

    // Lowest valid offset wins; descending loop leaves the smallest index in sel.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = SCAN - 1; k >= 0; k--) begin
            if (eff_valid[k]) begin
                hit = 1'b1;
                sel = SEL_W'(k);
            end
        end
    end

    // Saturating advance keeps the index from wrapping past the top of its range.
    always_comb begin
        adv      = hit ? ({{(IDX_W+1-SEL_W){1'b0}}, sel} + (IDX_W+1)'(1))
                       : (IDX_W+1)'(SCAN);
        idx_sum  = {1'b0, idx_reg} + adv;
        idx_next = idx_sum[IDX_W] ? {IDX_W{1'b1}} : idx_sum[IDX_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            idx_reg   <= '0;
            pos_reg   <= '0;
            fill_reg  <= 1'b0;
            head_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            full_reg  <= '0;
            for (int b = 0; b < 2; b++) begin
                count_reg[b] <= '0;
                for (int j = 0; j < LANES; j++) begin
                    w_reg[b][j]    <= '0;
                    ia_reg[b][j]   <= '0;
                    addr_reg[b][j] <= '0;
                end
            end
        end else begin
            done_reg <= 1'b0;

            // Consumer side: retire the oldest bank; banks always complete in order.
            if (full_reg[head_reg] && i_out_ack) begin
                full_reg[head_reg] <= 1'b0;
                head_reg           <= ~head_reg;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        len_reg   <= i_len;
                        idx_reg   <= '0;
                        pos_reg   <= '0;
                        fill_reg  <= 1'b0;
                        head_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (idx_reg >= len_reg) begin
                        state_reg <= ST_FLUSH;
                    end else if (full_reg[fill_reg]) begin
                        // Fill bank not yet consumed: hold everything.
                    end else if (hit) begin
                        w_reg[fill_reg][pos_reg]    <= win_w[sel];
                        ia_reg[fill_reg][pos_reg]   <= win_ia[sel];
                        addr_reg[fill_reg][pos_reg] <= win_addr[sel];
                        idx_reg                     <= idx_next;
                        if (pos_reg == CNT_W'(LANES - 1)) begin
                            full_reg[fill_reg]  <= 1'b1;
                            count_reg[fill_reg] <= CNT_W'(LANES);
                            fill_reg            <= ~fill_reg;
                            pos_reg             <= '0;
                        end else begin
                            pos_reg <= pos_reg + CNT_W'(1);
                        end
                    end else begin
                        idx_reg <= idx_next;
                    end
                end

                ST_FLUSH: begin
                    if (pos_reg == '0) begin
                        state_reg <= ST_DRAIN;
                    end else if (!full_reg[fill_reg]) begin
                        for (int j = 0; j < LANES; j++) begin
                            if (j >= int'(pos_reg)) begin
                                w_reg[fill_reg][j]    <= '0;
                                ia_reg[fill_reg][j]   <= '0;
                                addr_reg[fill_reg][j] <= '0;
                            end
                        end
                        full_reg[fill_reg]  <= 1'b1;
                        count_reg[fill_reg] <= pos_reg;
                        state_reg           <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (full_reg == 2'b00) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_out
            assign o_out_w[gi*DATA_W +: DATA_W]    = w_reg[head_reg][gi];
            assign o_out_ia[gi*DATA_W +: DATA_W]   = ia_reg[head_reg][gi];
            assign o_out_addr[gi*ADDR_W +: ADDR_W] = addr_reg[head_reg][gi];
        end
    endgenerate

    assign o_out_valid = full_reg[head_reg];
    assign o_out_bank  = head_reg;
    assign o_out_count = count_reg[head_reg];
    assign o_busy      = busy_reg;
    assign o_idx       = idx_reg;
    assign o_done      = done_reg;

endmodule

// File: tb/tb_vp_pingpong_encoder.sv
// Directed bench for vp_pingpong_encoder: a small upstream array feeds the window,
// and each accepted bank is captured and compared against hand-computed contents.
module tb_vp_pingpong_encoder;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_start;
    logic [10:0]    i_len;
    logic           o_busy;
    logic [10:0]    o_idx;
    logic [2:0]     i_win_valid;
    logic [47:0]    i_win_w;
    logic [47:0]    i_win_ia;
    logic [62:0]    i_win_addr;
    logic           o_out_valid;
    logic           i_out_ack;
    logic           o_out_bank;
    logic [1:0]     o_out_count;
    logic [47:0]    o_out_w;
    logic [47:0]    o_out_ia;
    logic [62:0]    o_out_addr;
    logic           o_done;

    int errors = 0;
    int checks = 0;

    vp_pingpong_encoder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
        .o_busy(o_busy), .o_idx(o_idx),
        .i_win_valid(i_win_valid), .i_win_w(i_win_w), .i_win_ia(i_win_ia),
        .i_win_addr(i_win_addr),
        .o_out_valid(o_out_valid), .i_out_ack(i_out_ack), .o_out_bank(o_out_bank),
        .o_out_count(o_out_count), .o_out_w(o_out_w), .o_out_ia(o_out_ia),
        .o_out_addr(o_out_addr), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // Upstream entry store: w = i+1, ia = 100+i, addr = {i, i+1, i+2}.
    logic           tv    [0:15];
    logic [15:0]    tw    [0:15];
    logic [15:0]    tia   [0:15];
    logic [20:0]    taddr [0:15];

    always_comb begin
        int j;
        i_win_valid = '0;
        i_win_w     = '0;
        i_win_ia    = '0;
        i_win_addr  = '0;
        j           = 0;
        for (int k = 0; k < 3; k++) begin
            j = int'(o_idx) + k;
            if (j < 16) begin
                i_win_valid[k]         = tv[j];
                i_win_w[k*16 +: 16]    = tw[j];
                i_win_ia[k*16 +: 16]   = tia[j];
                i_win_addr[k*21 +: 21] = taddr[j];
            end
        end
    end

    logic           cap_bank [0:7];
    logic [1:0]     cap_cnt  [0:7];
    logic [47:0]    cap_w    [0:7];
    logic [47:0]    cap_ia   [0:7];
    logic [62:0]    cap_addr [0:7];
    int             ncap;
    int             tr [0:15];
    int             ntr;
    bit             done_seen;
    bit             valid_seen;
    bit             first_busy;

    task automatic set_valid(input logic [15:0] mask);
        for (int i = 0; i < 16; i++) begin
            tv[i]    = mask[i];
            tw[i]    = 16'(i + 1);
            tia[i]   = 16'(100 + i);
            taddr[i] = {7'(i), 7'(i + 1), 7'(i + 2)};
        end
    endtask

    // Runs until o_done (bounded), recording index trace and every accepted bank.
    task automatic run(input bit do_start, input int len, input int budget);
        ncap = 0; ntr = 0; done_seen = 0; valid_seen = 0; first_busy = 0;
        if (do_start) begin
            @(negedge i_clk);
            i_len   = 11'(len);
            i_start = 1'b1;
        end
        for (int c = 0; c < budget; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (c == 0) first_busy = o_busy;
            if ((ntr == 0 || tr[ntr-1] != int'(o_idx)) && ntr < 16) begin
                tr[ntr] = int'(o_idx);
                ntr++;
            end
            if (o_out_valid) valid_seen = 1;
            if (o_out_valid && i_out_ack && ncap < 8) begin
                cap_bank[ncap] = o_out_bank;
                cap_cnt[ncap]  = o_out_count;
                cap_w[ncap]    = o_out_w;
                cap_ia[ncap]   = o_out_ia;
                cap_addr[ncap] = o_out_addr;
                ncap++;
            end
            if (o_done) begin
                done_seen = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_out_ack = 1'b1;
        set_valid(16'h0000);
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_busy, o_idx, o_out_valid, o_out_bank, o_out_count, o_done} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%0b idx=%0d valid=%0b bank=%0b count=%0d done=%0b expected all 0",
                     o_busy, o_idx, o_out_valid, o_out_bank, o_out_count, o_done);
        end
        checks++;
        if ({o_out_w, o_out_ia, o_out_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: got w=%0h ia=%0h addr=%0h expected 0", o_out_w, o_out_ia, o_out_addr);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_all_valid();
        i_out_ack = 1'b1;
        set_valid(16'h003F);
        run(1, 6, 200);
        checks++;
        if (first_busy !== 1'b1) begin
            errors++; $display("FAIL all_busy: got %0b expected 1", first_busy);
        end
        checks++;
        if (!done_seen || ncap != 2) begin
            errors++; $display("FAIL all_banks: got done=%0b banks=%0d expected done=1 banks=2", done_seen, ncap);
        end else begin
            checks++;
            if (cap_bank[0] !== 1'b0 || cap_cnt[0] !== 2'd3 || cap_w[0] !== {16'd3, 16'd2, 16'd1}) begin
                errors++;
                $display("FAIL all_bank0: got bank=%0b count=%0d w=%0h expected bank=0 count=3 w=000300020001",
                         cap_bank[0], cap_cnt[0], cap_w[0]);
            end
            checks++;
            if (cap_bank[1] !== 1'b1 || cap_cnt[1] !== 2'd3 || cap_w[1] !== {16'd6, 16'd5, 16'd4}) begin
                errors++;
                $display("FAIL all_bank1: got bank=%0b count=%0d w=%0h expected bank=1 count=3 w=000600050004",
                         cap_bank[1], cap_cnt[1], cap_w[1]);
            end
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL all_after_done: got done=%0b busy=%0b expected 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_sparse();
        i_out_ack = 1'b1;
        set_valid(16'h0124);
        run(1, 9, 200);
        checks++;
        if (ntr != 4 || tr[0] != 0 || tr[1] != 3 || tr[2] != 6 || tr[3] != 9) begin
            errors++;
            $display("FAIL sparse_idx: got n=%0d %0d %0d %0d %0d expected 4 0 3 6 9",
                     ntr, tr[0], tr[1], tr[2], tr[3]);
        end
        checks++;
        if (!done_seen || ncap != 1) begin
            errors++; $display("FAIL sparse_banks: got done=%0b banks=%0d expected 1 1", done_seen, ncap);
        end else begin
            checks++;
            if (cap_cnt[0] !== 2'd3 || cap_w[0] !== {16'd9, 16'd6, 16'd3}
                || cap_ia[0] !== {16'd108, 16'd105, 16'd102}) begin
                errors++;
                $display("FAIL sparse_data: got count=%0d w=%0h ia=%0h expected 3 000900060003 006c00690066",
                         cap_cnt[0], cap_w[0], cap_ia[0]);
            end
            checks++;
            if (cap_addr[0] !== {7'd8, 7'd9, 7'd10, 7'd5, 7'd6, 7'd7, 7'd2, 7'd3, 7'd4}) begin
                errors++; $display("FAIL sparse_addr: got %0h expected entries 8,5,2", cap_addr[0]);
            end
        end
    endtask

    task automatic test_flush();
        i_out_ack = 1'b1;
        set_valid(16'h000F);
        run(1, 7, 200);
        checks++;
        if (!done_seen || ncap != 2) begin
            errors++; $display("FAIL flush_banks: got done=%0b banks=%0d expected 1 2", done_seen, ncap);
        end else begin
            checks++;
            if (cap_cnt[0] !== 2'd3 || cap_w[0] !== {16'd3, 16'd2, 16'd1}) begin
                errors++; $display("FAIL flush_bank0: got count=%0d w=%0h expected 3 000300020001", cap_cnt[0], cap_w[0]);
            end
            checks++;
            if (cap_bank[1] !== 1'b1 || cap_cnt[1] !== 2'd1 || cap_w[1] !== {32'd0, 16'd4}
                || cap_ia[1] !== {32'd0, 16'd103}) begin
                errors++;
                $display("FAIL flush_bank1: got bank=%0b count=%0d w=%0h ia=%0h expected 1 1 4 67",
                         cap_bank[1], cap_cnt[1], cap_w[1], cap_ia[1]);
            end
            checks++;
            if (cap_addr[1] !== {42'd0, 7'd3, 7'd4, 7'd5}) begin
                errors++; $display("FAIL flush_addr: got %0h expected only entry 3 in slot 0", cap_addr[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        set_valid(16'h01FF);
        i_out_ack = 1'b0;
        @(negedge i_clk);
        i_len = 11'd9; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (14) @(negedge i_clk);
        checks++;
        if (o_idx !== 11'd6 || o_out_valid !== 1'b1 || o_out_bank !== 1'b0 || o_out_w[15:0] !== 16'd1) begin
            errors++;
            $display("FAIL stall_hold: got idx=%0d valid=%0b bank=%0b w0=%0d expected 6 1 0 1",
                     o_idx, o_out_valid, o_out_bank, o_out_w[15:0]);
        end
        i_out_ack = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_idx !== 11'd6 || o_out_valid !== 1'b1 || o_out_bank !== 1'b1 || o_out_w !== {16'd6, 16'd5, 16'd4}) begin
            errors++;
            $display("FAIL stall_ack1: got idx=%0d valid=%0b bank=%0b w=%0h expected 6 1 1 000600050004",
                     o_idx, o_out_valid, o_out_bank, o_out_w);
        end
        @(negedge i_clk);
        checks++;
        if (o_idx !== 11'd7) begin
            errors++; $display("FAIL stall_resume: got idx=%0d expected 7", o_idx);
        end
        run(0, 9, 200);
        checks++;
        if (!done_seen || ncap != 1 || cap_bank[0] !== 1'b0 || cap_w[0] !== {16'd9, 16'd8, 16'd7}) begin
            errors++;
            $display("FAIL stall_tail: got done=%0b banks=%0d bank=%0b w=%0h expected 1 1 0 000900080007",
                     done_seen, ncap, cap_bank[0], cap_w[0]);
        end
    endtask

    task automatic test_zero_len();
        i_out_ack = 1'b1;
        set_valid(16'hFFFF);
        run(1, 0, 50);
        checks++;
        if (!done_seen || valid_seen) begin
            errors++; $display("FAIL zero_len: got done=%0b valid_seen=%0b expected 1 0", done_seen, valid_seen);
        end
    endtask

    task automatic test_reset_mid_scan();
        i_out_ack = 1'b1;
        set_valid(16'h003F);
        @(negedge i_clk);
        i_len = 11'd6; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1; i_start = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0; i_start = 1'b0;
        checks++;
        if ({o_busy, o_idx, o_out_valid, o_out_bank, o_out_count, o_done} !== '0
            || {o_out_w, o_out_ia, o_out_addr} !== '0) begin
            errors++;
            $display("FAIL midrst: got busy=%0b idx=%0d valid=%0b bank=%0b count=%0d w=%0h expected all 0",
                     o_busy, o_idx, o_out_valid, o_out_bank, o_out_count, o_out_w);
        end
        test_all_valid();
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_sparse();
        test_flush();
        test_backpressure();
        test_zero_len();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
